// File: rtl/riscv_v_pipe_pkg.sv
// Shared types for the vector elastic pipe.
// Provides the occupancy count type and a popcount helper sized for the largest legal pipe.
package riscv_v_pipe_pkg;

  localparam int MAX_STAGES = 16;
  localparam int OCC_W      = 5;

  typedef logic [OCC_W-1:0] occ_t;

  function automatic occ_t popcount_f(input logic [MAX_STAGES-1:0] vec);
    occ_t cnt;
    cnt = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      cnt = cnt + occ_t'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/riscv_v_elastic_stage.sv
// One valid+payload register of the elastic pipe.
// Latency: 1 cycle when it loads.
// Backpressure: holds its entry while load is low; the load decision comes from the ready chain.
module riscv_v_elastic_stage #(
  parameter type DATA_T = logic
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  load,
  input  logic  v_prev,
  input  DATA_T d_prev,
  output logic  v_nxt,
  output logic  v,
  output DATA_T d
);

  always_comb begin
    v_nxt = v;
    if (flush) begin
      v_nxt = 1'b0;
    end else if (load) begin
      v_nxt = v_prev;
    end
  end

  // Payload only moves when a real entry arrives; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= v_nxt;
      if (!flush && load && v_prev) begin
        d <= d_prev;
      end
    end
  end

endmodule

// File: rtl/riscv_v_elastic_pipe.sv
// Elastic valid/ready pipe of NUM_STAGES registers between vector issue and execution lanes.
// Latency: NUM_STAGES cycles unstalled, throughput 1 per cycle.
// Backpressure: bubbles collapse; out_ready reaches in_ready combinationally through the ready chain.
module riscv_v_elastic_pipe
  import riscv_v_pipe_pkg::*;
#(
  parameter type DATA_T       = logic,
  parameter int  NUM_STAGES   = 2,
  localparam int CNT_W        = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  DATA_T                 in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output DATA_T                 out_data,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  empty
);

  logic [NUM_STAGES:0]     rdy;
  logic [NUM_STAGES-1:0]   v;
  logic [NUM_STAGES-1:0]   v_nxt;
  logic [MAX_STAGES-1:0]   v_pad;
  DATA_T                   d [NUM_STAGES];

  // A stage can take a new entry if it is empty or its successor can take its entry.
  always_comb begin
    rdy[NUM_STAGES] = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      rdy[i] = !v[i] | rdy[i+1];
    end
  end

  assign in_ready = rdy[0] & !flush;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      riscv_v_elastic_stage #(.DATA_T(DATA_T)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .load   (rdy[0]),
        .v_prev (in_valid & !flush),
        .d_prev (in_data),
        .v_nxt  (v_nxt[0]),
        .v      (v[0]),
        .d      (d[0])
      );
    end else begin : g_body
      riscv_v_elastic_stage #(.DATA_T(DATA_T)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .load   (rdy[i]),
        .v_prev (v[i-1]),
        .d_prev (d[i-1]),
        .v_nxt  (v_nxt[i]),
        .v      (v[i]),
        .d      (d[i])
      );
    end
  end

  always_comb begin
    v_pad                 = '0;
    v_pad[NUM_STAGES-1:0] = v_nxt;
  end

  // Counted from the next-state valids so it stays in lockstep with stage_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= CNT_W'(popcount_f(v_pad));
    end
  end

  assign empty       = (occupancy == '0);
  assign stage_valid = v;
  assign out_valid   = v[NUM_STAGES-1];
  assign out_data    = d[NUM_STAGES-1];

endmodule
